// File: rtl/lfsr_rng_range_if.sv
// lfsr_rng_range_if: draw request / drawn-value handshake between a consumer and lfsr_rng_range
interface lfsr_rng_range_if #(parameter int OUT_W = 11);
  logic req;
  logic req_ready;
  logic value_valid;
  logic value_ready;
  logic [OUT_W-1:0] value;
  modport master (output req, value_ready, input req_ready, value_valid, value);
  modport slave (input req, value_ready, output req_ready, value_valid, value);
endinterface

// File: rtl/lfsr_rng_range.sv
// lfsr_rng_range: Fibonacci LFSR with rejection-sampled draws in [MIN_VALUE, MAX_VALUE]; define LFSR_RNG_STATS_EN for draw/reject counters
module lfsr_rng_range #(
  parameter int WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS = 10'h240,
  parameter int SEED = 340,
  parameter int MIN_VALUE = 200,
  parameter int MAX_VALUE = 1223,
  parameter int MAX_TRIES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic seed_load,
  input  logic [WIDTH-1:0] seed_in,
  lfsr_rng_range_if.slave bus,
  output logic [WIDTH-1:0] lfsr_state,
  output logic lockup,
  output logic [15:0] draw_count,
  output logic [15:0] reject_count
);
  localparam int SPAN = MAX_VALUE - MIN_VALUE + 1;
  localparam int RW = $clog2(SPAN);
  localparam int OUT_W = $clog2(MAX_VALUE + 1);
  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
  state_t state;
  logic [WIDTH-1:0] lfsr;
  logic [7:0] tries;
  logic [OUT_W-1:0] value;
  logic value_valid;
  logic req_ready;
  logic [RW-1:0] cand;
  logic hit;
  logic last;
  assign cand = lfsr[RW-1:0];
  assign hit = 32'(cand) < SPAN;
  assign last = tries == 8'(MAX_TRIES - 1);
  assign lfsr_state = lfsr;
  assign bus.value = value;
  assign bus.value_valid = value_valid;
  assign bus.req_ready = req_ready;
  // LFSR register: reseed beats all-zero recovery beats advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lfsr <= WIDTH'(SEED);
      lockup <= 1'b0;
    end else begin
      lockup <= !seed_load && lfsr == '0;
      lfsr <= seed_load ? (seed_in == '0 ? WIDTH'(SEED) : seed_in)
            : lfsr == '0 ? WIDTH'(SEED)
            : (en || state == DRAW) ? {lfsr[WIDTH-2:0], ^(lfsr & TAPS)} : lfsr;
    end
  // draw FSM: accept a request, reject out-of-range candidates, fold on the last try, hold until taken
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tries <= '0;
      value <= OUT_W'(MIN_VALUE);
      value_valid <= 1'b0;
      req_ready <= 1'b1;
    end else
      case (state)
        IDLE: if (bus.req) begin
          state <= DRAW;
          tries <= '0;
          req_ready <= 1'b0;
        end
        DRAW: if (hit || last) begin
          state <= HOLD;
          value_valid <= 1'b1;
          value <= OUT_W'(MIN_VALUE) + OUT_W'(cand) - (hit ? '0 : OUT_W'(SPAN));
        end else
          tries <= tries + 8'd1;
        default: if (bus.value_ready) begin
          state <= IDLE;
          value_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
`ifdef LFSR_RNG_STATS_EN
  logic rej;
  logic done;
  assign rej = state == DRAW && !hit;
  assign done = state == HOLD && bus.value_ready;
  // saturating counters of completed draws and rejected candidates
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      draw_count <= '0;
      reject_count <= '0;
    end else begin
      draw_count <= draw_count + 16'(done && draw_count != 16'hFFFF);
      reject_count <= reject_count + 16'(rej && reject_count != 16'hFFFF);
    end
`else
  assign draw_count = '0;
  assign reject_count = '0;
`endif
endmodule

// File: tb/tb_lfsr_rng_range.sv
// tb_lfsr_rng_range: three parameterisations of lfsr_rng_range checked against a transaction-level draw model
module tb_lfsr_rng_range;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic seed_load = 1'b0;
  logic [9:0] seed_in = '0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int span[3] = '{1024, 1000, 1000};
  int mt[3] = '{8, 1, 4};
  logic [9:0] mx[3];
  int draws[3];
  int rejs[3];
`ifdef LFSR_RNG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  lfsr_rng_range_if #(.OUT_W(11)) b0 ();
  lfsr_rng_range_if #(.OUT_W(11)) b1 ();
  lfsr_rng_range_if #(.OUT_W(11)) b2 ();
  logic req_i[3];
  logic vr_i[3];
  logic rr_o[3];
  logic vv_o[3];
  logic lk_o[3];
  logic [10:0] val_o[3];
  logic [9:0] st_o[3];
  logic [15:0] dc_o[3];
  logic [15:0] rc_o[3];
  assign b0.req = req_i[0];
  assign b0.value_ready = vr_i[0];
  assign rr_o[0] = b0.req_ready;
  assign vv_o[0] = b0.value_valid;
  assign val_o[0] = b0.value;
  assign b1.req = req_i[1];
  assign b1.value_ready = vr_i[1];
  assign rr_o[1] = b1.req_ready;
  assign vv_o[1] = b1.value_valid;
  assign val_o[1] = b1.value;
  assign b2.req = req_i[2];
  assign b2.value_ready = vr_i[2];
  assign rr_o[2] = b2.req_ready;
  assign vv_o[2] = b2.value_valid;
  assign val_o[2] = b2.value;

  lfsr_rng_range u0 (.clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in), .bus(b0),
    .lfsr_state(st_o[0]), .lockup(lk_o[0]), .draw_count(dc_o[0]), .reject_count(rc_o[0]));
  lfsr_rng_range #(.MAX_VALUE(1199), .MAX_TRIES(1)) u1 (.clk(clk), .rst(rst), .en(en), .seed_load(seed_load),
    .seed_in(seed_in), .bus(b1), .lfsr_state(st_o[1]), .lockup(lk_o[1]), .draw_count(dc_o[1]), .reject_count(rc_o[1]));
  lfsr_rng_range #(.MAX_VALUE(1199), .MAX_TRIES(4)) u2 (.clk(clk), .rst(rst), .en(en), .seed_load(seed_load),
    .seed_in(seed_in), .bus(b2), .lfsr_state(st_o[2]), .lockup(lk_o[2]), .draw_count(dc_o[2]), .reject_count(rc_o[2]));

  typedef struct { logic [9:0] seed; int adv; logic [9:0] exp; } sv_t;
  typedef struct { int dut; logic [9:0] seed; int hold; int val; int lat; } dv_t;
  sv_t svec[7];
  dv_t dvec[7];

  function automatic logic [9:0] nx(input logic [9:0] x);
    return {x[8:0], x[9] ^ x[6]};
  endfunction

  // whole-draw model: walk candidates until one lands in range or the try budget is spent
  function automatic void draw_model(input int sp, input int tr, input logic [9:0] x0,
                                     output int val, output int lat, output int rej, output logic [9:0] x1);
    logic [9:0] x = x0;
    int rw = 0;
    while ((1 << rw) < sp) rw++;
    rej = 0;
    val = 0;
    lat = 0;
    x1 = x0;
    for (int t = 1; t <= tr; t++) begin
      int c = int'(x) % (1 << rw);
      x = nx(x);
      if (c < sp) begin
        val = 200 + c; lat = t; x1 = x;
        return;
      end
      rej++;
      if (t == tr) begin
        val = 200 + c - sp; lat = t; x1 = x;
        return;
      end
    end
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_lfsr();
    for (int i = 0; i < 3; i++) check("lfsr_track", st_o[i], mx[i]);
  endtask

  task automatic seed_task(input logic [9:0] s);
    seed_load = 1'b1;
    seed_in = s;
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 3; i++) mx[i] = (s == 10'd0) ? 10'd340 : s;
  endtask

  task automatic run(input int k);
    en = 1'b1;
    for (int c = 0; c < k; c++) begin
      tick();
      for (int i = 0; i < 3; i++) mx[i] = nx(mx[i]);
    end
    en = 1'b0;
  endtask

  task automatic do_draw(input int i, input int hold, output int got_v, output int got_l);
    int v, l, r, cyc;
    logic [9:0] x1;
    draw_model(span[i], mt[i], mx[i], v, l, r, x1);
    check("req_ready_idle", rr_o[i], 1);
    req_i[i] = 1'b1;
    tick();
    req_i[i] = 1'b0;
    check("req_ready_draw", rr_o[i], 0);
    cyc = 0;
    while (vv_o[i] !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    got_v = int'(val_o[i]);
    got_l = cyc;
    check("latency", cyc, l);
    check("value", val_o[i], v);
    check("lfsr_after_draw", st_o[i], x1);
    mx[i] = x1;
    rejs[i] += r;
    for (int k = 0; k < hold; k++) begin
      req_i[i] = k[0];
      tick();
      check("hold_value", val_o[i], v);
      check("hold_valid", vv_o[i], 1);
      check("hold_req_ready", rr_o[i], 0);
    end
    req_i[i] = 1'b0;
    vr_i[i] = 1'b1;
    tick();
    vr_i[i] = 1'b0;
    draws[i]++;
    check("valid_drop", vv_o[i], 0);
    check("req_ready_back", rr_o[i], 1);
    check("value_kept", val_o[i], v);
    check("draw_count", dc_o[i], STATS ? draws[i] : 0);
    check("reject_count", rc_o[i], STATS ? rejs[i] : 0);
  endtask

  initial begin
    int gv, gl;
    logic zero_seen, lk_seen, early;
    svec[0] = '{10'd0, 0, 10'd340};
    svec[1] = '{10'd1, 0, 10'd1};
    svec[2] = '{10'd1, 1, 10'd2};
    svec[3] = '{10'd1, 2, 10'd4};
    svec[4] = '{10'd1, 3, 10'd8};
    svec[5] = '{10'd340, 1, 10'd681};
    svec[6] = '{10'd512, 1, 10'd1};
    dvec[0] = '{1, 10'd1010, 0, 210, 1};
    dvec[1] = '{2, 10'd1010, 0, 1196, 2};
    dvec[2] = '{2, 10'd1023, 0, 216, 4};
    dvec[3] = '{1, 10'd1023, 0, 223, 1};
    dvec[4] = '{0, 10'd1023, 0, 1223, 1};
    dvec[5] = '{1, 10'd999, 20, 1199, 1};
    dvec[6] = '{2, 10'd1000, 3, 1176, 2};
    for (int i = 0; i < 3; i++) begin
      req_i[i] = 1'b0; vr_i[i] = 1'b0; mx[i] = 10'd340; draws[i] = 0; rejs[i] = 0;
    end
    #1 rst = 1'b1;
    #2;
    check("rst_value", val_o[0], 200);
    check("rst_valid", vv_o[0], 0);
    check("rst_req_ready", rr_o[0], 1);
    check("rst_lfsr", st_o[0], 340);
    check("rst_lockup", lk_o[0], 0);
    check("rst_draw_count", dc_o[0], 0);
    check("rst_reject_count", rc_o[0], 0);
    #4 rst = 1'b0;
    tick();
    do_draw(0, 0, gv, gl);
    check("first_draw_value", gv, 540);
    check("first_draw_lfsr", st_o[0], 681);
    do_draw(0, 0, gv, gl);
    check("second_draw_value", gv, 881);
    chk_lfsr();
    for (int n = 0; n < 7; n++) begin
      seed_task(svec[n].seed);
      run(svec[n].adv);
      check("seed_vector", st_o[0], svec[n].exp);
    end
    for (int n = 0; n < 7; n++) begin
      seed_task(dvec[n].seed);
      do_draw(dvec[n].dut, dvec[n].hold, gv, gl);
      check("table_value", gv, dvec[n].val);
      check("table_latency", gl, dvec[n].lat);
      chk_lfsr();
    end
    seed_task(10'd340);
    zero_seen = 1'b0; lk_seen = 1'b0; early = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 1023; c++) begin
      tick();
      if (st_o[0] == 10'd0) zero_seen = 1'b1;
      if (lk_o[0]) lk_seen = 1'b1;
      if (c < 1022 && st_o[0] == 10'd340) early = 1'b1;
    end
    en = 1'b0;
    check("period_return", st_o[0], 340);
    check("period_nonzero", zero_seen, 0);
    check("period_lockup_quiet", lk_seen, 0);
    check("period_not_short", early, 0);
    chk_lfsr();
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: seed_task(($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)));
        1: run($urandom_range(1, 15));
        default: do_draw($urandom_range(0, 2), $urandom_range(0, 3), gv, gl);
      endcase
      chk_lfsr();
    end
    seed_task(10'd1023);
    req_i[2] = 1'b1;
    tick();
    req_i[2] = 1'b0;
    tick();
    check("mid_draw_busy", rr_o[2], 0);
    #2 rst = 1'b1;
    #1;
    check("async_valid", vv_o[2], 0);
    check("async_value", val_o[2], 200);
    check("async_lfsr", st_o[2], 340);
    check("async_req_ready", rr_o[2], 1);
    check("async_draw_count", dc_o[2], 0);
    check("async_reject_count", rc_o[2], 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mx[i] = 10'd340; draws[i] = 0; rejs[i] = 0;
    end
    tick();
    chk_lfsr();
    do_draw(2, 0, gv, gl);
    check("post_reset_value", gv, 540);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
